// File: rtl/genius_pkg.sv
// genius_pkg: state codes and display-select constants for the Genius control unit
package genius_pkg;
    typedef enum logic [2:0] {
        INIT     = 3'd0,
        SETUP    = 3'd1,
        SEQUENCE = 3'd2,
        PLAY     = 3'd3,
        CHECK    = 3'd4,
        NEXT     = 3'd5,
        RESULT   = 3'd6
    } state_t;
    localparam logic SEL_GAME   = 1'b0;
    localparam logic SEL_RESULT = 1'b1;
endpackage

// File: rtl/genius_control_edge_sync.sv
// edge_sync: two-flop synchronizer plus registered rising-edge detector (3-clock latency)
module edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic [2:0] sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= {3{RST_VAL}};
            pulse <= 1'b0;
        end else begin
            sh    <= {sh[1:0], d};
            pulse <= sh[1] & ~sh[2];
        end
    end
endmodule

// File: rtl/genius_control.sv
// genius_control: Moore FSM sequencing the Genius game datapath strobes
module genius_control
    import genius_pkg::*;
#(
    parameter int WAIT_CYCLES = 25_000_000,
    parameter int CNT_W       = $clog2(WAIT_CYCLES + 1)
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       enter,
    input  logic       end_FPGA,
    input  logic       end_User,
    input  logic       end_time,
    input  logic       match,
    input  logic       win,
    output logic       R1,
    output logic       R2,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       SEL,
    output logic [2:0] state_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enter_p;

    // Flops reset high so a key held through reset yields no edge
    edge_sync #(.RST_VAL(1'b1)) u_enter (
        .clk  (CLOCK_50),
        .rst_n(reset_n),
        .d    (enter),
        .pulse(enter_p)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = INIT;
        case (state_q)
            INIT:     state_d = SETUP;
            SETUP:    state_d = enter_p ? SEQUENCE : SETUP;
            SEQUENCE: state_d = end_FPGA ? PLAY : SEQUENCE;
            PLAY:     state_d = end_time ? RESULT : (end_User ? CHECK : PLAY);
            CHECK:    state_d = (match && !win) ? NEXT : RESULT;
            NEXT:     state_d = (cnt_q == CNT_LAST) ? SEQUENCE : NEXT;
            RESULT:   state_d = enter_p ? INIT : RESULT;
            default:  state_d = INIT;
        endcase
        cnt_d = (state_q == NEXT && cnt_q != CNT_LAST) ? cnt_q + 1'b1 : '0;
    end

    assign R1      = state_q == INIT;
    assign R2      = state_q == INIT || state_q == NEXT;
    assign E1      = state_q == SETUP;
    assign E2      = state_q == PLAY;
    assign E3      = state_q == SEQUENCE;
    assign E4      = state_q == NEXT && cnt_q == '0;
    assign SEL     = state_q == RESULT ? SEL_RESULT : SEL_GAME;
    assign state_o = state_q;
endmodule

// File: tb/tb_genius_control.sv
// tb_genius_control: randomized scoreboard bench against a behavioural game model
module tb_genius_control;
    localparam int WAIT = 4;
    logic       CLOCK_50 = 1'b0;
    logic       reset_n, enter, end_FPGA, end_User, end_time, match, win;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state_o;
    int         checks = 0, fails = 0, cyc = 0;
    int         ph = 0, rem = 0;
    bit         hist[$];
    logic [9:0] exp_q[$];

    genius_control #(.WAIT_CYCLES(WAIT)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enter(enter),
        .end_FPGA(end_FPGA), .end_User(end_User), .end_time(end_time),
        .match(match), .win(win),
        .R1(R1), .R2(R2), .E1(E1), .E2(E2), .E3(E3), .E4(E4),
        .SEL(SEL), .state_o(state_o)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Phase 0..6 mirrors the game flow; rem counts pause cycles still to spend in NEXT
    function automatic logic [9:0] model_out(int p, int r);
        return {p == 0, p == 0 || p == 5, p == 1, p == 3, p == 2,
                p == 5 && r == WAIT, p == 6, 3'(p)};
    endfunction

    always @(posedge CLOCK_50) begin
        bit ep;
        if (!reset_n) begin
            ph = 0;
            rem = 0;
            hist = '{1, 1, 1, 1, 1};
        end else begin
            hist.push_front(enter);
            ep = hist[3] & ~hist[4];
            void'(hist.pop_back());
            case (ph)
                0: ph = 1;
                1: if (ep) ph = 2;
                2: if (end_FPGA) ph = 3;
                3: if (end_time) ph = 6; else if (end_User) ph = 4;
                4: begin ph = (match && !win) ? 5 : 6; rem = WAIT; end
                5: begin rem--; if (rem == 0) ph = 2; end
                default: if (ep) ph = 0;
            endcase
        end
        exp_q.push_back(model_out(ph, rem));
    end

    always @(posedge CLOCK_50) begin
        logic [9:0] got, e;
        #1;
        cyc++;
        got = {R1, R2, E1, E2, E3, E4, SEL, state_o};
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty cycle %0d got %b", cyc, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL outputs cycle %0d got %b exp %b (R1 R2 E1 E2 E3 E4 SEL state)", cyc, got, e);
            end
        end
    end

    task automatic rand_inputs();
        if ($urandom_range(7) == 0) enter = ~enter;
        end_FPGA = $urandom_range(3) == 0;
        end_User = $urandom_range(3) == 0;
        end_time = $urandom_range(9) == 0;
        match    = $urandom_range(3) != 0;
        win      = $urandom_range(3) == 0;
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({R1, R2, E1, E2, E3, E4, SEL, state_o} !== 10'b11_0000_0_000) begin
            fails++;
            $display("FAIL async_reset got %b exp %b", {R1, R2, E1, E2, E3, E4, SEL, state_o}, 10'b11_0000_0_000);
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
    endtask

    initial begin
        bit hit;
        {enter, end_FPGA, end_User, end_time, match, win} = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (100) @(negedge CLOCK_50);
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLOCK_50);
            rand_inputs();
            if ($urandom_range(299) == 0) async_reset();
            if (i % 500 == 499) begin
                hit = 0;
                for (int k = 0; k < 3000 && !hit; k++) begin
                    @(negedge CLOCK_50);
                    if (ph == 5) hit = 1; else rand_inputs();
                end
                if (hit) async_reset();
                else begin
                    checks++;
                    fails++;
                    $display("FAIL reach_next got timeout exp phase 5");
                end
            end
        end
        repeat (3) @(negedge CLOCK_50);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/genius_control.md
Name: genius_control

Overview:
- Moore control unit for the Genius (Simon) game. It drives the datapath's reset, enable and display-select strobes (R1, R2, E1–E4, SEL).
- It consumes the datapath status flags (end_FPGA, end_User, end_time, win, match).
- It sequences the game through setup, FPGA sequence playback, user entry, comparison, round advance and result display.
- It sits beside the datapath at top level, on the same CLOCK_50 domain.

Parameters:
- WAIT_CYCLES, 25_000_000: length in CLOCK_50 cycles of the inter-round pause in state NEXT. Legal range is 1 or more; 25_000_000 is 0.5 s at 50 MHz.
- CNT_W, $clog2(WAIT_CYCLES+1): width of the pause counter.

Ports:
- CLOCK_50 in 1: system clock, 50 MHz.
- reset_n in 1: one clock; reset is asynchronous and active-low.
- enter in 1: start/confirm button, active-high level, asynchronous to CLOCK_50 (already-inverted KEY).
- end_FPGA in 1: datapath finished playing the current sequence.
- end_User in 1: user has entered ROUND presses.
- end_time in 1: user entry timer expired.
- match in 1: FPGA and user sequences equal (qualified by end_User).
- win in 1: final round reached.
- R1 out 1: global datapath reset (setup, round).
- R2 out 1: per-round reset (timer, user/FPGA counters and registers).
- E1 out 1: setup register load enable.
- E2 out 1: user entry and timer enable.
- E3 out 1: FPGA sequence playback enable.
- E4 out 1: round counter increment enable.
- SEL out 1: display select; 0 = game display, 1 = result display.
- state_o out 3: current state code, for debug.

Behaviour:
- States and encoding: INIT=0, SETUP=1, SEQUENCE=2, PLAY=3, CHECK=4, NEXT=5, RESULT=6. Code 7 is illegal and goes to INIT on the next clock.
- Reset (reset_n=0, async): state=INIT, pause counter=0, enter synchronizer flops=1.
- Reset output values: R1=1, R2=1, E1..E4=0, SEL=0, state_o=0.
- Outputs are Moore outputs, decoded from the state register plus the pause counter. Any output not listed for a state is 0.
  - INIT: R1=1, R2=1.
  - SETUP: E1=1.
  - SEQUENCE: E3=1.
  - PLAY: E2=1.
  - CHECK: all strobes 0.
  - NEXT: R2=1 every cycle; E4=1 only on the first cycle (counter==0).
  - RESULT: SEL=1.
- Enter handling:
  - Two-flop synchronizer, then a rising-edge detector, giving a one-cycle pulse enter_p.
  - Latency from enter rising to enter_p is 3 clocks.
  - Synchronizer flops reset to 1, so a key held through reset produces no edge.
  - enter_p is honoured only in SETUP and RESULT; it is ignored in every other state.
- Transitions (evaluated each rising CLOCK_50):
  - INIT -> SETUP unconditionally (INIT lasts 1 cycle).
  - SETUP -> SEQUENCE on enter_p.
  - SEQUENCE -> PLAY when end_FPGA=1.
  - PLAY -> RESULT when end_time=1. Otherwise PLAY -> CHECK when end_User=1. If both are high in the same cycle, end_time wins.
  - CHECK -> RESULT if match=0. Otherwise -> RESULT if win=1. Otherwise -> NEXT. CHECK lasts exactly 1 cycle.
  - NEXT: counter increments each cycle. When counter==WAIT_CYCLES-1, go to SEQUENCE and clear the counter. With WAIT_CYCLES=1, NEXT lasts 1 cycle and E4 and R2 are both asserted in it.
  - RESULT -> INIT on enter_p. From INIT the R1 pulse clears setup and round.
- Pause counter: cleared in every state other than NEXT. It never wraps because the exit fires at WAIT_CYCLES-1.
- reset_n asserted mid-game (any state): immediate INIT outputs, with no completion of pending strobes.
- Status inputs are sampled synchronously only; they come from the CLOCK_50 datapath, so no synchronization is required.

Decomposition:
- Package genius_pkg:
  - state enum/localparams (3-bit codes above);
  - display-select constants SEL_GAME=0, SEL_RESULT=1.
- One sub-module: edge_sync. It holds the two-flop synchronizer and the rising-edge detector. Its reset value is a parameter, set to 1 here.

Test Plan:
- Reset then idle: release reset_n with enter=0 → INIT for 1 cycle with R1=R2=1, then SETUP with E1=1, holding there for 100 cycles.
- Start and playback: in SETUP, pulse enter high for 5 cycles → state_o=2 after 3–4 clocks with E3=1. Then drive end_FPGA=1 → state_o=3 next clock with E2=1.
- Correct round, no win (WAIT_CYCLES=4): in PLAY assert end_User=1, match=1, win=0 → CHECK (1 cycle), then NEXT for 4 cycles with R2=1 and E4=1 only on the first cycle, then SEQUENCE.
- Mismatch and timeout:
  - match=0 at CHECK → RESULT with SEL=1.
  - Separately, end_time=1 and end_User=1 together in PLAY → RESULT directly, CHECK skipped.
- Win and restart: match=1, win=1 at CHECK → RESULT with SEL=1. Then an enter pulse → INIT (R1=1), then SETUP.
- Glitch guards:
  - enter held high through a reset_n pulse → stays in SETUP.
  - enter pulsed during PLAY → ignored.
  - reset_n low during NEXT → outputs equal INIT values asynchronously, before the next clock edge.
